trap_peak_detector_v_4: RTL and testbench
=========================================

Name: trap_peak_detector_v_4

Overview:
- Sits directly downstream of the trapezoidal shaping filter (rise K = 9, flat top L = 5, pole-zero M = 16).
- Consumes the filter's signed output stream and detects each shaped pulse with a threshold state machine.
- For each accepted pulse, emits one event record: peak amplitude, sample timestamp of the peak, pulse width and a pile-up flag.
- The event record feeds the spectrum/histogram logic.

Parameters:
- DATA_W, 16, width of signed filter output sample.
- K, 9, trapezoid rise length in samples; must match the filter setting.
- L, 5, trapezoid flat-top length in samples; must match the filter setting.
- MIN_W, 9, minimum above-threshold width (samples) for an event to be accepted.
- HOLD_W, 8, number of samples ignored after each pulse ends.
- TS_W, 32, timestamp counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  filter output sample strobe.
- in_data  in  DATA_W  signed filter output sample.
- threshold  in  DATA_W  signed trigger level, sampled each in_valid.
- peak_valid  out  1  one-clock pulse marking a new event record.
- peak_amp  out  DATA_W  signed maximum sample of the pulse.
- peak_time  out  TS_W  timestamp of the maximum sample.
- peak_width  out  8  above-threshold sample count, saturating at 255.
- pileup  out  1  set when peak_width > 2*K+L.
- busy  out  1  high in ACTIVE or HOLD.

Behaviour:
- Reset (reset = 0, asynchronous):
  - All outputs 0.
  - State IDLE; ts counter 0; max register 0; width counter 0; hold counter 0.
  - Asserting reset mid-pulse discards the pulse; no event is emitted after release.
- Timestamp:
  - ts increments by 1 on every in_valid, wrapping mod 2^TS_W.
  - A sample's timestamp is the ts value before its increment. The first sample after reset has ts = 0.
- FSM state advances only on in_valid cycles. Comparisons are signed; "above" means in_data > threshold (strict).
- IDLE:
  - Sample above → ACTIVE; max = in_data; max_ts = ts; width = 1.
- ACTIVE, sample above:
  - width += 1, saturating at 255.
  - If in_data > max: max = in_data, max_ts = ts. Ties keep the earlier timestamp.
- ACTIVE, sample not above (the terminating sample):
  - If width >= MIN_W: on the next clock, peak_valid = 1 for exactly one clock. peak_amp, peak_time, peak_width and pileup are loaded in that same clock and held until the next event.
  - If width < MIN_W: the pulse is discarded; no peak_valid; outputs keep their previous values.
  - Either way, go to HOLD with hold counter = HOLD_W. If HOLD_W = 0, go straight to IDLE.
  - The terminating sample never starts a new pulse.
- HOLD:
  - Each in_valid decrements the hold counter; the input is ignored.
  - When the counter reaches 0 after a decrement → IDLE. The next sample is then eligible to trigger.
- busy = 1 in ACTIVE and HOLD; 0 in IDLE.
- Gaps in in_valid (cycles with in_valid = 0) freeze FSM, counters and ts. peak_valid is independent of in_valid.
- Latency: peak_valid rises one clock after the clock in which the terminating sample has in_valid = 1.
- Saturated width (255) forces pileup = 1. Amplitude is never truncated (full DATA_W).
- Threshold changing mid-pulse takes effect on the next sample's comparison.

Test Plan:
- Clean trapezoid, threshold = 100:
  - Stimulus after reset: 10×0, ramp 111·i for i = 1..9, 5×1000, ramp 888 down to 111 in steps of 111, then 0s, continuous in_valid.
  - Required: one peak_valid one clock after sample idx 32; peak_amp = 1000, peak_time = 19, peak_width = 22, pileup = 0; busy falls after 8 more samples.
- Runt: 4 samples of 500 between zeros → no peak_valid; busy high for 4 + 1 + 8 sample periods.
- Pile-up: two overlapping trapezoids giving 40 consecutive samples above threshold, maximum 1800 → peak_width = 40, pileup = 1, peak_amp = 1800.
- Holdoff: a second pulse starting 5 samples after the first terminates is ignored until HOLD ends. A pulse starting at 9 samples after termination is detected, with peak_time equal to its own sample index.
- Gapped in_valid: the clean trapezoid with in_valid = 1 every 3rd clock → identical peak_amp, peak_time and peak_width to the first scenario; latency of one clock after the terminating strobe.
- Reset mid-pulse: drop reset during the flat top, release, feed zeros → no peak_valid; all outputs 0; ts restarts at 0.

Source files
------------

// File: rtl/trap_peak_detector_v_4.sv
// Pulse detector for the trapezoidal shaper output stream.
// Tracks each above-threshold pulse (peak amplitude, peak timestamp, width),
// emits one event record per accepted pulse and then holds off for HOLD_W samples.
// Ports:
//   clk, reset (async, active-low)
//   in_valid, in_data, threshold  : sample strobe, signed sample, signed trigger level
//   peak_valid                    : one-clock strobe for a new event record
//   peak_amp, peak_time           : signed peak value and its timestamp
//   peak_width, pileup            : saturating above-threshold count, pile-up flag
//   busy                          : pulse in progress or holdoff running
module trap_peak_detector_v_4 #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned K      = 9,
  parameter int unsigned L      = 5,
  parameter int unsigned MIN_W  = 9,
  parameter int unsigned HOLD_W = 8,
  parameter int unsigned TS_W   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] threshold,
  output logic                     peak_valid,
  output logic signed [DATA_W-1:0] peak_amp,
  output logic [TS_W-1:0]          peak_time,
  output logic [7:0]               peak_width,
  output logic                     pileup,
  output logic                     busy
);

  localparam int unsigned WIDTH_W  = 8;
  localparam int unsigned HOLD_CW  = (HOLD_W < 2) ? 1 : $clog2(HOLD_W + 1);
  localparam int unsigned PILE_LIM = 2 * K + L;
  localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  state_e                     state_q,  state_d;
  logic [TS_W-1:0]            ts_q,     ts_d;
  logic signed [DATA_W-1:0]   max_q,    max_d;
  logic [TS_W-1:0]            max_ts_q, max_ts_d;
  logic [WIDTH_W-1:0]         width_q,  width_d;
  logic [HOLD_CW-1:0]         hold_q,   hold_d;
  logic                       peak_valid_q, peak_valid_d;
  logic signed [DATA_W-1:0]   peak_amp_q,   peak_amp_d;
  logic [TS_W-1:0]            peak_time_q,  peak_time_d;
  logic [WIDTH_W-1:0]         peak_width_q, peak_width_d;
  logic                       pileup_q,     pileup_d;
  logic                       busy_q,       busy_d;
  logic                       above;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ts_q         <= '0;
      max_q        <= '0;
      max_ts_q     <= '0;
      width_q      <= '0;
      hold_q       <= '0;
      peak_valid_q <= 1'b0;
      peak_amp_q   <= '0;
      peak_time_q  <= '0;
      peak_width_q <= '0;
      pileup_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ts_q         <= ts_d;
      max_q        <= max_d;
      max_ts_q     <= max_ts_d;
      width_q      <= width_d;
      hold_q       <= hold_d;
      peak_valid_q <= peak_valid_d;
      peak_amp_q   <= peak_amp_d;
      peak_time_q  <= peak_time_d;
      peak_width_q <= peak_width_d;
      pileup_q     <= pileup_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and event-record logic; everything freezes while in_valid is low
  always_comb begin
    state_d      = state_q;
    ts_d         = ts_q;
    max_d        = max_q;
    max_ts_d     = max_ts_q;
    width_d      = width_q;
    hold_d       = hold_q;
    peak_valid_d = 1'b0;
    peak_amp_d   = peak_amp_q;
    peak_time_d  = peak_time_q;
    peak_width_d = peak_width_q;
    pileup_d     = pileup_q;
    above        = in_data > threshold;

    if (in_valid) begin
      ts_d = ts_q + TS_W'(1);
      unique case (state_q)
        S_IDLE: begin
          if (above) begin
            state_d  = S_ACTIVE;
            max_d    = in_data;
            max_ts_d = ts_q;
            width_d  = WIDTH_W'(1);
          end
        end
        S_ACTIVE: begin
          if (above) begin
            if (width_q != WIDTH_MAX) begin
              width_d = width_q + WIDTH_W'(1);
            end
            // Strict compare keeps the earliest sample on ties
            if (in_data > max_q) begin
              max_d    = in_data;
              max_ts_d = ts_q;
            end
          end else begin
            if (32'(width_q) >= MIN_W) begin
              peak_valid_d = 1'b1;
              peak_amp_d   = max_q;
              peak_time_d  = max_ts_q;
              peak_width_d = width_q;
              pileup_d     = (width_q == WIDTH_MAX) || (32'(width_q) > PILE_LIM);
            end
            // Terminating sample is consumed here and never retriggers
            if (HOLD_W == 0) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_HOLD;
              hold_d  = HOLD_CW'(HOLD_W);
            end
          end
        end
        S_HOLD: begin
          hold_d = hold_q - HOLD_CW'(1);
          if (hold_q == HOLD_CW'(1)) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign peak_valid = peak_valid_q;
  assign peak_amp   = peak_amp_q;
  assign peak_time  = peak_time_q;
  assign peak_width = peak_width_q;
  assign pileup     = pileup_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_trap_peak_detector_v_4.sv
// Testbench for trap_peak_detector_v_4: scenario table plus randomized streams,
// all checked cycle by cycle against a pulse-segment reference model.
module tb_trap_peak_detector_v_4;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned K      = 9;
  localparam int unsigned L      = 5;
  localparam int unsigned MIN_W  = 9;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned TS_W   = 32;
  localparam int MAXN = 512;
  localparam int HW   = int'(HOLD_W);

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic signed [DATA_W-1:0] threshold;
  logic                     peak_valid;
  logic signed [DATA_W-1:0] peak_amp;
  logic [TS_W-1:0]          peak_time;
  logic [7:0]               peak_width;
  logic                     pileup;
  logic                     busy;

  always #5 clk = ~clk;

  trap_peak_detector_v_4 #(
    .DATA_W(DATA_W), .K(K), .L(L), .MIN_W(MIN_W), .HOLD_W(HOLD_W), .TS_W(TS_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .threshold(threshold), .peak_valid(peak_valid), .peak_amp(peak_amp),
    .peak_time(peak_time), .peak_width(peak_width), .pileup(pileup), .busy(busy)
  );

  // Stimulus stream and model expectations, indexed by sample number
  int data_a[MAXN];
  int thr_a[MAXN];
  int gap_a[MAXN];
  int n_samp;
  bit ev_a[MAXN];
  int ev_amp[MAXN];
  int ev_time[MAXN];
  int ev_width[MAXN];
  bit ev_pile[MAXN];
  bit busy_a[MAXN];
  int model_events;

  int checks = 0;
  int errors = 0;
  int n_events;
  int m_amp, m_time, m_width;
  bit m_pile;

  typedef struct {
    int kind;
    int gap;
    bit has_exp;
    int exp_events;
    int exp_amp;
    int exp_time;
    int exp_width;
    bit exp_pile;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Ideal trapezoid: 9-sample rise, 5-sample flat top, 8-sample fall
  function automatic int trap(input int n, input int step, input int amp);
    if (n < 0)  return 0;
    if (n < 9)  return step * (n + 1);
    if (n < 14) return amp;
    if (n < 22) return step * (8 - (n - 14));
    return 0;
  endfunction

  // Reference model: scan whole above-threshold runs rather than stepping a state machine
  function automatic void build_model();
    int k, j, elig, mx, mt, w;
    model_events = 0;
    for (int i = 0; i < n_samp; i++) begin
      ev_a[i] = 0;
      busy_a[i] = 0;
    end
    k = 0;
    elig = 0;
    while (k < n_samp) begin
      if (k >= elig && data_a[k] > thr_a[k]) begin
        j = k;
        mx = data_a[k];
        mt = k;
        while (j < n_samp && data_a[j] > thr_a[j]) begin
          if (data_a[j] > mx) begin
            mx = data_a[j];
            mt = j;
          end
          j++;
        end
        for (int b = k; b < j + HW && b < n_samp; b++) busy_a[b] = 1;
        if (j < n_samp && (j - k) >= int'(MIN_W)) begin
          w = (j - k > 255) ? 255 : j - k;
          ev_a[j] = 1;
          ev_amp[j] = mx;
          ev_time[j] = mt;
          ev_width[j] = w;
          ev_pile[j] = (w > int'(2 * K + L));
          model_events++;
        end
        elig = j + HW + 1;
        k = j + 1;
      end else begin
        k++;
      end
    end
  endfunction

  task automatic check_held(input string tag);
    chk({tag, "_amp"}, peak_amp, m_amp);
    chk({tag, "_time"}, peak_time, m_time);
    chk({tag, "_width"}, peak_width, m_width);
    chk({tag, "_pileup"}, pileup, m_pile);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_peak_valid", peak_valid, 0);
    chk("rst_busy", busy, 0);
    m_amp = 0; m_time = 0; m_width = 0; m_pile = 0;
    check_held("rst");
    reset = 1'b1;
  endtask

  // Drive samples 0..n_drive-1 of the current stream, checking every clock
  task automatic run_stream(input int n_drive);
    build_model();
    n_events = 0;
    for (int k = 0; k < n_drive; k++) begin
      for (int g = 0; g < gap_a[k]; g++) begin
        in_valid = 1'b0;
        in_data = DATA_W'($urandom);
        threshold = DATA_W'($urandom);
        @(posedge clk);
        #1;
        chk("gap_peak_valid", peak_valid, 0);
        chk("gap_busy", busy, (k > 0) ? busy_a[k-1] : 1'b0);
        check_held("gap");
      end
      in_valid = 1'b1;
      in_data = DATA_W'(data_a[k]);
      threshold = DATA_W'(thr_a[k]);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (ev_a[k]) begin
        m_amp = ev_amp[k];
        m_time = ev_time[k];
        m_width = ev_width[k];
        m_pile = ev_pile[k];
      end
      chk("peak_valid", peak_valid, ev_a[k]);
      if (peak_valid === 1'b1) n_events++;
      chk("busy", busy, busy_a[k]);
      check_held("out");
    end
  endtask

  task automatic build(input int kind, input int gap);
    int thr, rem, up;
    rem = 0;
    up = 0;
    thr = 100;
    n_samp = (kind == 6) ? 330 : (kind >= 7) ? 400 : (kind == 3) ? 80 : 90;
    for (int k = 0; k < n_samp; k++) begin
      thr_a[k] = 100;
      gap_a[k] = gap;
      case (kind)
        0, 1:    data_a[k] = trap(k - 10, 111, 1000);
        2:       data_a[k] = (k >= 10 && k < 14) ? 500 : 0;
        3:       data_a[k] = trap(k - 10, 111, 1000) + trap(k - 28, 200, 1800);
        4:       data_a[k] = trap(k - 10, 111, 1000) + trap(k - 37, 111, 1000);
        5:       data_a[k] = trap(k - 10, 111, 1000) + trap(k - 41, 111, 1000);
        6:       data_a[k] = (k == 100 || k == 200) ? 700 : (k >= 10 && k < 310) ? 500 : 0;
        default: begin
          if (k < n_samp - 30) begin
            if (rem == 0) begin
              rem = int'($urandom_range(1, 30));
              up = int'($urandom_range(0, 1));
            end
            rem--;
            if ($urandom_range(0, 15) == 0) thr = int'($urandom_range(0, 400)) - 200;
            thr_a[k] = thr;
            data_a[k] = (up == 1) ? thr + 1 + 100 * int'($urandom_range(0, 7))
                                  : thr - 100 * int'($urandom_range(0, 3));
          end else begin
            data_a[k] = 0;
          end
          if (kind != 9) gap_a[k] = int'($urandom_range(0, 2));
        end
      endcase
    end
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    threshold = '0;

    //                kind gap has  evs  amp  time width pile
    tbl[0] = '{0, 0, 1'b1, 1, 1000,  19,  22, 1'b0};
    tbl[1] = '{1, 2, 1'b1, 1, 1000,  19,  22, 1'b0};
    tbl[2] = '{2, 0, 1'b1, 0,    0,   0,   0, 1'b0};
    tbl[3] = '{3, 0, 1'b1, 1, 1800,  36,  40, 1'b1};
    tbl[4] = '{4, 0, 1'b1, 2, 1000,  46,  18, 1'b0};
    tbl[5] = '{5, 0, 1'b1, 2, 1000,  50,  22, 1'b0};
    tbl[6] = '{6, 0, 1'b1, 1,  700, 100, 255, 1'b1};
    tbl[7] = '{7, 0, 1'b0, 0,    0,   0,   0, 1'b0};
    tbl[8] = '{8, 0, 1'b0, 0,    0,   0,   0, 1'b0};
    tbl[9] = '{9, 0, 1'b0, 0,    0,   0,   0, 1'b0};

    for (int t = 0; t < 10; t++) begin
      apply_reset();
      build(tbl[t].kind, tbl[t].gap);
      run_stream(n_samp);
      chk("event_count_model", n_events, model_events);
      if (tbl[t].has_exp) begin
        chk("tbl_events", n_events, tbl[t].exp_events);
        chk("tbl_amp", peak_amp, tbl[t].exp_amp);
        chk("tbl_time", peak_time, tbl[t].exp_time);
        chk("tbl_width", peak_width, tbl[t].exp_width);
        chk("tbl_pileup", pileup, tbl[t].exp_pile);
        chk("tbl_idle_at_end", busy, 0);
      end
    end

    // Reset in the middle of a pulse's flat top, after an earlier event was recorded
    apply_reset();
    build(5, 0);
    run_stream(53);
    chk("pre_rst_amp", peak_amp, 1000);
    chk("pre_rst_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_peak_valid", peak_valid, 0);
    m_amp = 0; m_time = 0; m_width = 0; m_pile = 0;
    check_held("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Zeros after release, then a clean pulse whose timestamp proves ts restarted
    n_samp = 100;
    for (int k = 0; k < n_samp; k++) begin
      data_a[k] = trap(k - 50, 111, 1000);
      thr_a[k] = 100;
      gap_a[k] = 0;
    end
    run_stream(n_samp);
    chk("post_rst_events", n_events, 1);
    chk("post_rst_ts_restart", peak_time, 59);
    chk("post_rst_amp", peak_amp, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
